// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that gate decode issue on RAW hazards.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle retire clear a single-write hazard.
module reg_scoreboard #(
    parameter int                  ADDR_WID   = 4,
    parameter int                  NUM_OF_REG = 15,
    parameter logic [ADDR_WID-1:0] RNONE      = 4'hF,
    parameter int                  CNT_WID    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  issue_valid,
    input  logic [ADDR_WID-1:0]   issue_srcA,
    input  logic [ADDR_WID-1:0]   issue_srcB,
    input  logic [ADDR_WID-1:0]   issue_destE,
    input  logic [ADDR_WID-1:0]   issue_destM,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [ADDR_WID-1:0]   wb_destE,
    input  logic [ADDR_WID-1:0]   wb_destM,
    output logic [NUM_OF_REG-1:0] pending_mask,
    output logic                  err_underflow
);

    localparam logic [CNT_WID-1:0] CNT_MAX = {CNT_WID{1'b1}};
    localparam logic [CNT_WID-1:0] CNT_ONE = CNT_WID'(1);

    function automatic logic id_ok(input logic [ADDR_WID-1:0] id);
        return (id != RNONE) && (int'(id) < NUM_OF_REG);
    endfunction

    logic [CNT_WID-1:0]    r_cnt [NUM_OF_REG];
    logic [NUM_OF_REG-1:0] r_pending;
    logic                  r_err;

    logic                  w_a_ok, w_b_ok, w_de_ok, w_dm_ok, w_we_ok, w_wm_ok;
    logic [CNT_WID-1:0]    w_cnt_a, w_cnt_b, w_cnt_de, w_cnt_dm;
    logic                  w_byp_a, w_byp_b;
    logic                  w_haz_a, w_haz_b, w_sat_e, w_sat_m;
    logic                  w_fire;
    logic [NUM_OF_REG-1:0] w_inc, w_dec, w_uflow, w_pending_nxt;
    logic [CNT_WID-1:0]    w_cnt_nxt [NUM_OF_REG];

    assign w_a_ok  = id_ok(issue_srcA);
    assign w_b_ok  = id_ok(issue_srcB);
    assign w_de_ok = id_ok(issue_destE);
    assign w_dm_ok = id_ok(issue_destM);
    assign w_we_ok = id_ok(wb_destE);
    assign w_wm_ok = id_ok(wb_destM);

    // Out-of-range ids match no entry, so their looked-up count reads as zero.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_cnt_a  = '0;
        w_cnt_b  = '0;
        w_cnt_de = '0;
        w_cnt_dm = '0;
        for (int r = 0; r < NUM_OF_REG; r++) begin
            if (issue_srcA  == ADDR_WID'(r)) w_cnt_a  = r_cnt[r];
            if (issue_srcB  == ADDR_WID'(r)) w_cnt_b  = r_cnt[r];
            if (issue_destE == ADDR_WID'(r)) w_cnt_de = r_cnt[r];
            if (issue_destM == ADDR_WID'(r)) w_cnt_dm = r_cnt[r];
        end
    end

    always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
        // A lone outstanding write retiring now is forwarded, so the consumer need not wait.
        w_byp_a = wb_valid && (w_cnt_a == CNT_ONE) &&
                  ((issue_srcA == wb_destE) || (issue_srcA == wb_destM));
        w_byp_b = wb_valid && (w_cnt_b == CNT_ONE) &&
                  ((issue_srcB == wb_destE) || (issue_srcB == wb_destM));
`else
        w_byp_a = 1'b0;
        w_byp_b = 1'b0;
`endif
        w_haz_a = w_a_ok && (w_cnt_a != '0) && !w_byp_a;
        w_haz_b = w_b_ok && (w_cnt_b != '0) && !w_byp_b;
        w_sat_e = w_de_ok && (w_cnt_de == CNT_MAX);
        w_sat_m = w_dm_ok && (w_cnt_dm == CNT_MAX);
    end

    assign issue_ready = !(w_haz_a || w_haz_b || w_sat_e || w_sat_m);
    assign w_fire      = issue_valid && issue_ready;

    // destE == destM collapses to a single increment (and likewise for retire) because the bits are ORed.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 0; r < NUM_OF_REG; r++) begin
            w_inc[r] = w_fire && ((w_de_ok && (issue_destE == ADDR_WID'(r))) ||
                                  (w_dm_ok && (issue_destM == ADDR_WID'(r))));
            w_dec[r] = wb_valid && ((w_we_ok && (wb_destE == ADDR_WID'(r))) ||
                                    (w_wm_ok && (wb_destM == ADDR_WID'(r))));
        end
    end

    always_comb begin
        w_uflow       = '0;
        w_pending_nxt = '0;
        for (int r = 0; r < NUM_OF_REG; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
            w_uflow[r]   = w_dec[r] && (r_cnt[r] == '0);
            unique case ({w_inc[r], w_dec[r]})
                2'b10:   w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
                2'b01:   w_cnt_nxt[r] = (r_cnt[r] == '0) ? '0 : r_cnt[r] - CNT_ONE;
                default: w_cnt_nxt[r] = r_cnt[r];
            endcase
            w_pending_nxt[r] = (w_cnt_nxt[r] != '0);
        end
    end

    // NOTE: the counter array is reset explicitly; a stale count after reset would forge a hazard forever.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NUM_OF_REG; r++) r_cnt[r] <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_OF_REG; r++) r_cnt[r] <= w_cnt_nxt[r];
            r_pending <= w_pending_nxt;
            r_err     <= r_err || (|w_uflow);
        end
    end

    assign pending_mask  = r_pending;
    assign err_underflow = r_err;

endmodule
